// File: rtl/uart_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_rx                                                          |
// | Purpose  : UART receiver, 8N1 (or 8E1), LSB first. The asynchronous serial  |
// |            input is oversampled by clk and each bit is sampled mid-bit.     |
// |            Each good byte is emitted as a one-cycle o_vld pulse.            |
// |            There is no backpressure.                                        |
// | Ports    : clk     in   system clock, posedge                               |
// |            rst_n   in   asynchronous active-low reset                       |
// |            i_rx    in   serial line, idle high, asynchronous to clk         |
// |            o_data  out  [7:0] last received byte, held between frames       |
// |            o_vld   out  one-cycle pulse per correctly framed byte           |
// |            o_perr  out  parity error, qualified by o_vld (parity build only)|
// | Macro    : UART_RX_PARITY_EN - adds an even-parity bit and the o_perr port  |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module uart_rx #(
  parameter int FREQ = 1_000_000,
  parameter int RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_vld
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_perr
`endif
);

  localparam int DIV  = FREQ / RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);   // wide enough to hold DIV-1

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd5;
`endif

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          shift_en;
  logic          done;
`ifdef UART_RX_PARITY_EN
  logic          par_en;
  logic          par_bit;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (baud_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!rx_s) state_nxt = S_START;
      // A start bit that is high again at mid-bit was a glitch.
      S_START:     if (tick) state_nxt = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:      if (tick && bit_cnt == 3'd7) state_nxt = S_PARITY;
      S_PARITY:    if (tick) state_nxt = S_STOP;
`else
      S_DATA:      if (tick && bit_cnt == 3'd7) state_nxt = S_STOP;
`endif
      // Back to IDLE on the stop sample itself, so a start bit that
      // follows the stop bit without a gap is still caught.
      S_STOP:      if (tick) state_nxt = rx_s ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_s) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = DIV_M1;
    shift_en = 1'b0;
    done     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // Half a bit to the middle of the start bit.
        cnt_load = !rx_s;
        cnt_val  = HALF_M1;
      end
      S_START: cnt_load = tick;
      S_DATA: begin
        cnt_load = tick;
        shift_en = tick;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        cnt_load = tick;
        par_en   = tick;
      end
`endif
      S_STOP:  done = tick && rx_s;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      o_data   <= 8'h00;
      o_vld    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
      o_perr   <= 1'b0;
`endif
    end else begin
      // Reloaded at every sample point, so timing error never accumulates.
      if (cnt_load)       baud_cnt <= cnt_val;
      else if (!tick)     baud_cnt <= baud_cnt - CNT_ONE;

      if (shift_en) begin
        shreg   <= {rx_s, shreg[7:1]};   // LSB arrives first
        bit_cnt <= bit_cnt + 3'd1;       // wraps 7 -> 0 after the last bit
      end

      o_vld <= done;
      if (done) o_data <= shreg;
`ifdef UART_RX_PARITY_EN
      if (par_en) par_bit <= rx_s;
      o_perr <= done && ((^shreg) ^ par_bit);
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_uart_rx                                                       |
// | Purpose  : Self-checking bench for uart_rx. Frames are driven bit by bit;   |
// |            each good frame pushes its expected byte onto a scoreboard that  |
// |            is popped and compared when o_vld pulses.                        |
// | Macro    : UART_RX_PARITY_EN - adds the even-parity cases                   |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_uart_rx;

  localparam int FREQ = 1_000_000;
  localparam int RATE = 115_200;
  localparam int DIV  = FREQ / RATE;
  localparam int HALF = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif
  // i_rx fall to o_vld high: 2 synchronizer cycles + mid-stop sample + 1 register
  localparam int LAT = HALF + STOP_IDX * DIV + 1 + 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       vld;
  logic       perr;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         fall;
  } exp_t;

  exp_t sb[$];
  int   cyc       = 0;
  int   n_vec     = 0;
  int   n_err     = 0;
  int   vld_count = 0;
  int   last_vld  = 0;
  int   gap       = 0;
  logic prev_vld  = 1'b0;

  uart_rx #(.FREQ(FREQ), .RATE(RATE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rx   (rx),
    .o_data (data),
    .o_vld  (vld)
`ifdef UART_RX_PARITY_EN
    ,
    .o_perr (perr)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  initial clk = 1'b0;
  always #1 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at a negedge; leaves the line high (or low after a bad stop bit)
  // at a negedge so frames can be chained with no idle gap.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    exp_t e;
    if (stop) begin
      e.data = b;
      e.perr = (^b) ^ par;
      e.fall = cyc;
      sb.push_back(e);
    end
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (DIV) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    repeat (DIV) @(negedge clk);
`endif
    rx = stop;
    repeat (DIV) @(negedge clk);
    if (stop) rx = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output monitor / scoreboard pop
  always @(negedge clk) begin
    if (vld) begin
      exp_t e;
      vld_count++;
      check("vld_width", prev_vld, 1'b0);
      if (sb.size() == 0) begin
        check("unexpected_vld", vld, 1'b0);
      end else begin
        e = sb.pop_front();
        check("data", data, e.data);
        check("latency", cyc - e.fall, LAT);
`ifdef UART_RX_PARITY_EN
        check("perr", perr, e.perr);
`endif
      end
      gap      = cyc - last_vld;
      last_vld = cyc;
    end
    prev_vld = vld;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(3);
    check("rst_vld", vld, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_perr", perr, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // Basic frame
    cnt0 = vld_count;
    send_frame(8'h6A, ^8'h6A, 1'b1);
    wait_drain();
    idle(20);
    check("t1_one_pulse", vld_count - cnt0, 1);

    // Short low glitch must not start a frame
    cnt0 = vld_count;
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(40);
    check("t2_glitch_no_vld", vld_count - cnt0, 0);
    send_frame(8'hC3, ^8'hC3, 1'b1);
    wait_drain();
    idle(20);

    // Framing error followed by a long break
    cnt0 = vld_count;
    send_frame(8'h55, ^8'h55, 1'b0);
    idle(200);
    check("t3_ferr_no_vld", vld_count - cnt0, 0);
    check("t3_data_held", data, 8'hC3);
    rx = 1'b1;
    idle(20);
    send_frame(8'hA3, ^8'hA3, 1'b1);
    wait_drain();
    idle(20);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, ^8'h00, 1'b1);
    send_frame(8'hFF, ^8'hFF, 1'b1);
    wait_drain();
    check("t4_gap", gap, DIV * (STOP_IDX + 1));
    idle(20);

    // Reset in the middle of a frame
    cnt0 = vld_count;
    rx = 1'b0;
    idle(DIV);
    for (int k = 0; k < 4; k++) begin
      rx = k[0] ? 1'b1 : 1'b0;   // 8'h5A, bits 0..3 = 0,1,0,1
      idle(DIV);
    end
    rx    = 1'b1;
    rst_n = 1'b0;
    idle(1);
    check("t5_rst_vld", vld, 1'b0);
    check("t5_rst_data", data, 8'h00);
    idle(2);
    rst_n = 1'b1;
    idle(100);
    check("t5_no_vld", vld_count - cnt0, 0);
    send_frame(8'h3C, ^8'h3C, 1'b1);
    wait_drain();
    idle(20);

`ifdef UART_RX_PARITY_EN
    // Parity good, then parity bad (still delivered, flagged)
    send_frame(8'h6A, 1'b0, 1'b1);
    wait_drain();
    idle(10);
    send_frame(8'h6A, 1'b1, 1'b1);
    wait_drain();
    idle(10);
`endif

    check("final_queue", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
